// File: rtl/cu_sequencer.sv
// Drives one compute_unit through diff/square/accumulate for every dimension of every centroid,
// then reports the nearest centroid (argmin of squared distance) and its distance.
module cu_sequencer #(
  parameter int unsigned DW     = 8,
  parameter int unsigned NDIM   = 2,
  parameter int unsigned NCLUST = 4,
  localparam int unsigned CW    = (NCLUST > 1) ? $clog2(NCLUST) : 1,
  localparam int unsigned PAW   = (NDIM > 1) ? $clog2(NDIM) : 1,
  localparam int unsigned CAW   = (NCLUST * NDIM > 1) ? $clog2(NCLUST * NDIM) : 1
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           point_wr_i,
  input  logic [PAW-1:0] point_addr_i,
  input  logic [DW-1:0]  point_data_i,
  input  logic           cent_wr_i,
  input  logic [CAW-1:0] cent_addr_i,
  input  logic [DW-1:0]  cent_data_i,
  input  logic           start_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [CW-1:0]  cluster_o,
  output logic [DW-1:0]  dist_o,
  output logic           cu_enable_o,
  output logic [2:0]     cu_ctrl_o,
  output logic [DW-1:0]  cu_prev_accum_o,
  output logic [DW-1:0]  cu_centroid_o,
  output logic           cu_centroid_valid_o,
  output logic [DW-1:0]  cu_data_o,
  output logic           cu_data_valid_o,
  input  logic [DW-1:0]  cu_res_i
);

  typedef enum logic [2:0] {
    StIdle, StLoad, StDiff, StSqr, StAcc, StCmp, StDone
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  k_q, k_d;
  logic [PAW-1:0] d_q, d_d;
  logic [DW-1:0]  accum_q, accum_d;
  logic [DW-1:0]  best_q, best_d;
  logic [CW-1:0]  best_k_q, best_k_d;
  logic [CW-1:0]  cluster_q, cluster_d;
  logic [DW-1:0]  dist_q, dist_d;

  logic [DW-1:0]  point_q [NDIM];
  logic [DW-1:0]  point_d [NDIM];
  logic [DW-1:0]  cent_q  [NCLUST*NDIM];
  logic [DW-1:0]  cent_d  [NCLUST*NDIM];

  logic [CAW-1:0] cent_idx;
  logic           last_d, last_k, take_new;
  logic [DW-1:0]  new_best;
  logic [CW-1:0]  new_best_k;
  logic           wr_ok;

  assign cent_idx = CAW'(k_q) * CAW'(NDIM) + CAW'(d_q);
  assign last_d   = (32'(d_q) == NDIM - 1);
  assign last_k   = (32'(k_q) == NCLUST - 1);
  // Strict less-than keeps the lower index on ties.
  assign take_new   = (k_q == '0) || (accum_q < best_q);
  assign new_best   = take_new ? accum_q : best_q;
  assign new_best_k = take_new ? k_q : best_k_q;
  // Host writes only land while idle; writes during a run are dropped.
  assign wr_ok      = (state_q == StIdle) && !reset_i;

  // Register-file write decode, out-of-range addresses ignored.
  always_comb begin
    point_d = point_q;
    cent_d  = cent_q;
    if (wr_ok && point_wr_i && (32'(point_addr_i) < NDIM)) begin
      point_d[point_addr_i] = point_data_i;
    end
    if (wr_ok && cent_wr_i && (32'(cent_addr_i) < NCLUST * NDIM)) begin
      cent_d[cent_addr_i] = cent_data_i;
    end
  end

  // Register files are not reset.
  always_ff @(posedge clk_i) begin
    point_q <= point_d;
    cent_q  <= cent_d;
  end

  // Next-state and compute_unit drive.
  always_comb begin
    state_d             = state_q;
    k_d                 = k_q;
    d_d                 = d_q;
    accum_d             = accum_q;
    best_d              = best_q;
    best_k_d            = best_k_q;
    cluster_d           = cluster_q;
    dist_d              = dist_q;
    done_o              = 1'b0;
    cu_ctrl_o           = 3'b000;
    cu_prev_accum_o     = '0;
    cu_centroid_o       = '0;
    cu_centroid_valid_o = 1'b0;
    cu_data_o           = '0;
    cu_data_valid_o     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StLoad;
          k_d     = '0;
          d_d     = '0;
          accum_d = '0;
        end
      end
      StLoad: begin
        cu_data_o           = point_q[d_q];
        cu_data_valid_o     = 1'b1;
        cu_centroid_o       = cent_q[cent_idx];
        cu_centroid_valid_o = 1'b1;
        state_d             = StDiff;
      end
      StDiff: begin
        cu_ctrl_o = 3'b001;
        state_d   = StSqr;
      end
      StSqr: begin
        cu_ctrl_o = 3'b010;
        state_d   = StAcc;
      end
      StAcc: begin
        cu_ctrl_o       = 3'b100;
        cu_prev_accum_o = accum_q;
        accum_d         = cu_res_i;
        if (last_d) begin
          state_d = StCmp;
        end else begin
          d_d     = d_q + PAW'(1);
          state_d = StLoad;
        end
      end
      StCmp: begin
        best_d   = new_best;
        best_k_d = new_best_k;
        if (last_k) begin
          // Publish directly so the result is visible during the done cycle.
          cluster_d = new_best_k;
          dist_d    = new_best;
          state_d   = StDone;
        end else begin
          k_d     = k_q + CW'(1);
          d_d     = '0;
          accum_d = '0;
          state_d = StLoad;
        end
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      k_q       <= '0;
      d_q       <= '0;
      accum_q   <= '0;
      best_q    <= '0;
      best_k_q  <= '0;
      cluster_q <= '0;
      dist_q    <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      d_q       <= d_d;
      accum_q   <= accum_d;
      best_q    <= best_d;
      best_k_q  <= best_k_d;
      cluster_q <= cluster_d;
      dist_q    <= dist_d;
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign cu_enable_o = busy_o;
  assign cluster_o   = cluster_q;
  assign dist_o      = dist_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// Bench for cu_sequencer: ideal compute_unit model, a schedule/argmin reference model checked
// every cycle, plus directed runs with literal expected results.
module tb_cu_sequencer;
  localparam int DW     = 8;
  localparam int NDIM   = 2;
  localparam int NCLUST = 4;
  localparam int PER    = 4 * NDIM + 1;
  localparam int LAT    = NCLUST * PER + 1;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       point_wr_i = 1'b0;
  logic [0:0] point_addr_i = '0;
  logic [7:0] point_data_i = '0;
  logic       cent_wr_i = 1'b0;
  logic [2:0] cent_addr_i = '0;
  logic [7:0] cent_data_i = '0;
  logic       start_i = 1'b0;
  logic       busy_o, done_o, cu_enable_o, cu_centroid_valid_o, cu_data_valid_o;
  logic [1:0] cluster_o;
  logic [7:0] dist_o, cu_prev_accum_o, cu_centroid_o, cu_data_o, cu_res;
  logic [2:0] cu_ctrl_o;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  cu_sequencer #(.DW(DW), .NDIM(NDIM), .NCLUST(NCLUST)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .point_wr_i(point_wr_i), .point_addr_i(point_addr_i), .point_data_i(point_data_i),
    .cent_wr_i(cent_wr_i), .cent_addr_i(cent_addr_i), .cent_data_i(cent_data_i),
    .start_i(start_i), .busy_o(busy_o), .done_o(done_o), .cluster_o(cluster_o), .dist_o(dist_o),
    .cu_enable_o(cu_enable_o), .cu_ctrl_o(cu_ctrl_o), .cu_prev_accum_o(cu_prev_accum_o),
    .cu_centroid_o(cu_centroid_o), .cu_centroid_valid_o(cu_centroid_valid_o),
    .cu_data_o(cu_data_o), .cu_data_valid_o(cu_data_valid_o), .cu_res_i(cu_res)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sqd(input int x, input int c);
    int df;
    df = x - c;
    return 8'(df * df);
  endfunction

  // Ideal compute_unit: latch operands on valid, accumulate result is combinational.
  logic [7:0] cu_x, cu_c;
  always @(posedge clk) begin
    if (cu_data_valid_o) cu_x <= cu_data_o;
    if (cu_centroid_valid_o) cu_c <= cu_centroid_o;
  end
  assign cu_res = (cu_ctrl_o == 3'b100) ? 8'(cu_prev_accum_o + sqd(cu_x, cu_c)) : 8'd0;

  // Reference model: cycle index within a run plus shadow register files.
  int         m_t = 0;
  logic [7:0] mp [NDIM];
  logic [7:0] mc [NCLUST*NDIM];
  int         m_cl = 0;
  int         m_ds = 0;

  function automatic int dist_k(input int k);
    logic [7:0] s;
    s = 8'd0;
    for (int d = 0; d < NDIM; d++) s = 8'(s + sqd(mp[d], mc[k*NDIM+d]));
    return int'(s);
  endfunction

  function automatic int best_k();
    int b;
    b = 0;
    for (int k = 1; k < NCLUST; k++) if (dist_k(k) < dist_k(b)) b = k;
    return b;
  endfunction

  always @(posedge clk) begin
    if (reset_i) begin
      m_t  <= 0;
      m_cl <= 0;
      m_ds <= 0;
    end else if (m_t == 0) begin
      if (point_wr_i && point_addr_i < NDIM) mp[point_addr_i] <= point_data_i;
      if (cent_wr_i && cent_addr_i < NCLUST * NDIM) mc[cent_addr_i] <= cent_data_i;
      if (start_i) m_t <= 1;
    end else if (m_t == LAT) begin
      m_t <= 0;
    end else begin
      if (m_t == LAT - 1) begin
        m_cl <= best_k();
        m_ds <= dist_k(best_k());
      end
      m_t <= m_t + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0d act=%0h exp=%0h", name, m_t, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model's schedule.
  task automatic compare();
    int pos, k, r, d, ph, pa, ctl;
    bit ld, run;
    if (!chk_en) return;
    run = (m_t != 0);
    ld  = 1'b0;
    ctl = 0;
    pa  = 0;
    k   = 0;
    d   = 0;
    if (run && m_t < LAT) begin
      pos = m_t - 1;
      k   = pos / PER;
      r   = pos % PER;
      if (r != PER - 1) begin
        d  = r / 4;
        ph = r % 4;
        ld = (ph == 0);
        ctl = (ph == 0) ? 0 : (1 << (ph - 1));
        if (ph == 3) begin
          for (int j = 0; j < d; j++) pa = (pa + int'(sqd(mp[j], mc[k*NDIM+j]))) % 256;
        end
      end
    end
    chk("busy", busy_o, run);
    chk("enable", cu_enable_o, run);
    chk("done", done_o, m_t == LAT);
    chk("ctrl", cu_ctrl_o, ctl);
    chk("dvalid", cu_data_valid_o, ld);
    chk("cvalid", cu_centroid_valid_o, ld);
    chk("prev_accum", cu_prev_accum_o, pa);
    chk("cluster", cluster_o, m_cl);
    chk("dist", dist_o, m_ds);
    if (ld) begin
      chk("data", cu_data_o, mp[d]);
      chk("centroid", cu_centroid_o, mc[k*NDIM+d]);
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
  endtask

  task automatic load(input int p0, input int p1, input int c[8]);
    point_wr_i = 1'b1;
    for (int i = 0; i < NDIM; i++) begin
      point_addr_i = 1'(i);
      point_data_i = 8'((i == 0) ? p0 : p1);
      step();
    end
    point_wr_i = 1'b0;
    cent_wr_i = 1'b1;
    for (int i = 0; i < NCLUST * NDIM; i++) begin
      cent_addr_i = 3'(i);
      cent_data_i = 8'(c[i]);
      step();
    end
    cent_wr_i = 1'b0;
  endtask

  // kind: 0 plain, 1 start+cent write mid-run, 2 reset mid-run, 3 cent[7]=3 written with start.
  task automatic run(input string tag, input int kind, input int act_cyc, input int ecl,
                     input int eds, input int exp_nd, input int exp_cyc);
    int dc, dn;
    dc = -1;
    dn = 0;
    start_i = 1'b1;
    if (kind == 3) begin
      cent_wr_i   = 1'b1;
      cent_addr_i = 3'd7;
      cent_data_i = 8'd3;
    end
    step();
    start_i   = 1'b0;
    cent_wr_i = 1'b0;
    for (int i = 1; i <= LAT + 4; i++) begin
      if (done_o === 1'b1) begin
        dn++;
        if (dc < 0) dc = i;
        chk({tag, "_cluster"}, cluster_o, ecl);
        chk({tag, "_dist"}, dist_o, eds);
      end
      if (kind == 2 && i == act_cyc + 1) chk({tag, "_rst_busy"}, busy_o, 0);
      if (i == act_cyc && kind == 1) begin
        start_i     = 1'b1;
        cent_wr_i   = 1'b1;
        cent_addr_i = 3'd2;
        cent_data_i = 8'd0;
      end
      if (i == act_cyc && kind == 2) reset_i = 1'b1;
      if (i < LAT + 4) step();
      start_i   = 1'b0;
      cent_wr_i = 1'b0;
      reset_i   = 1'b0;
    end
    chk({tag, "_ndone"}, dn, exp_nd);
    chk({tag, "_cycle"}, dc, exp_cyc);
  endtask

  initial begin
    step();
    step();
    chk_en = 1'b1;
    reset_i = 1'b0;
    step();
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_cluster", cluster_o, 0);
    chk("rst_dist", dist_o, 0);
    chk("rst_ctrl", cu_ctrl_o, 0);

    load(3, 4, '{0, 0, 3, 4, 5, 5, 9, 9});
    run("t1", 0, 0, 1, 0, 1, 37);
    run("t4", 1, 5, 1, 0, 1, 37);
    run("t4b", 0, 0, 1, 0, 1, 37);
    run("t5", 2, 10, 0, 0, 0, -1);
    run("t5b", 0, 0, 1, 0, 1, 37);

    load(2, 2, '{0, 2, 4, 2, 9, 9, 7, 7});
    run("t2", 0, 0, 0, 4, 1, 37);

    load(0, 0, '{15, 0, 1, 1, 12, 0, 0, 0});
    run("t3", 3, 0, 1, 2, 1, 37);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0d", m_t);
    $fatal(1, "timeout");
  end
endmodule
